// File: rtl/column_scanner.sv
// Column scanner for a multiplexed LED/key matrix.
// Drives one ring stage at a time with dwell and blanking phases.
module column_scanner #(
  parameter int COLS       = 5,
  parameter int MIRROR     = 1,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1,
  parameter int ACTIVE_LOW = 0,
  localparam int RING = (MIRROR != 0) ? (COLS + 1) / 2 : COLS,
  localparam int IW   = (RING > 1) ? $clog2(RING) : 1
) (
  input  logic            clock,
  input  logic            pulse,
  input  logic            enable,
  input  logic            reverse,
  output logic [RING-1:0] col,
  output logic [COLS-1:0] col_phys,
  output logic [IW-1:0]   col_idx,
  output logic            blank,
  output logic            frame_start
);

  localparam int CMAX0 = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CMAX  = (CMAX0 > 2) ? CMAX0 : 2;
  localparam int CW    = $clog2(CMAX);

  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] LAST  = IW'(RING - 1);
  localparam logic [RING-1:0] RING_RST = RING'(1 << (RING - 1));

  typedef enum logic {SCAN, BLNK} phase_t;

  phase_t          phase, phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RING-1:0] ring, ring_n;
  logic [RING-1:0] rot_f, rot_r;
  logic [IW-1:0]   idx, idx_n;
  logic            adv, wrap, fs_n;
  logic [RING-1:0] masked;
  logic [COLS-1:0] phys_m;

  // Forward walks toward stage 0, reverse toward RING-1.
  for (genvar i = 0; i < RING; i++) begin : g_rot
    assign rot_f[i] = ring[(i + 1) % RING];
    assign rot_r[i] = ring[(i + RING - 1) % RING];
  end

  always_ff @(posedge clock or negedge pulse) begin
    if (!pulse) begin
      phase       <= SCAN;
      cnt         <= '0;
      ring        <= RING_RST;
      idx         <= LAST;
      frame_start <= 1'b0;
    end else begin
      phase       <= phase_n;
      cnt         <= cnt_n;
      ring        <= ring_n;
      idx         <= idx_n;
      frame_start <= fs_n;
    end
  end

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    adv     = 1'b0;
    if (enable) begin
      unique case (phase)
        SCAN: begin
          if (cnt == DLAST) begin
            cnt_n = '0;
            if (BLANK > 0) phase_n = BLNK;
            else           adv     = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        BLNK: begin
          if (cnt == BLAST) begin
            cnt_n   = '0;
            adv     = 1'b1;
            phase_n = SCAN;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: phase_n = SCAN;
      endcase
    end
    wrap   = reverse ? (idx == LAST) : (idx == '0);
    ring_n = ring;
    idx_n  = idx;
    if (adv) begin
      ring_n = reverse ? rot_r : rot_f;
      if (reverse) idx_n = (idx == LAST) ? '0 : idx + IW'(1);
      else         idx_n = (idx == '0) ? LAST : idx - IW'(1);
    end
    fs_n = adv & wrap;
  end

  always_comb begin
    blank    = (phase == BLNK);
    masked   = ring & ~{RING{blank}};
    col      = (ACTIVE_LOW != 0) ? ~masked : masked;
    col_phys = (ACTIVE_LOW != 0) ? ~phys_m : phys_m;
    col_idx  = idx;
  end

  // Mirrored pairs: outer columns share a stage, folding toward the centre.
  for (genvar p = 0; p < COLS; p++) begin : g_phys
    localparam int MP  = (p < COLS - 1 - p) ? p : COLS - 1 - p;
    localparam int SRC = (MIRROR != 0) ? MP : p;
    assign phys_m[p] = masked[SRC];
  end

endmodule

// File: tb/tb_column_scanner.sv
// Bench for column_scanner: three configurations against a
// slot-time reference model, plus hand-computed sequences.
module tb_column_scanner;

  logic clock = 1'b0;
  logic pulse = 1'b0;
  logic enable = 1'b0;
  logic reverse = 1'b0;

  always #5 clock = ~clock;

  logic [2:0] a_col;
  logic [4:0] a_phys;
  logic [1:0] a_idx;
  logic       a_blank, a_fs;
  logic [3:0] b_col, b_phys;
  logic [1:0] b_idx;
  logic       b_blank, b_fs;
  logic [2:0] c_col;
  logic [5:0] c_phys;
  logic [1:0] c_idx;
  logic       c_blank, c_fs;

  column_scanner u_a (
    .clock(clock), .pulse(pulse), .enable(enable), .reverse(reverse),
    .col(a_col), .col_phys(a_phys), .col_idx(a_idx),
    .blank(a_blank), .frame_start(a_fs)
  );

  column_scanner #(
    .COLS(4), .MIRROR(0), .DWELL(2), .BLANK(0), .ACTIVE_LOW(0)
  ) u_b (
    .clock(clock), .pulse(pulse), .enable(enable), .reverse(reverse),
    .col(b_col), .col_phys(b_phys), .col_idx(b_idx),
    .blank(b_blank), .frame_start(b_fs)
  );

  column_scanner #(
    .COLS(6), .MIRROR(1), .DWELL(3), .BLANK(2), .ACTIVE_LOW(1)
  ) u_c (
    .clock(clock), .pulse(pulse), .enable(enable), .reverse(reverse),
    .col(c_col), .col_phys(c_phys), .col_idx(c_idx),
    .blank(c_blank), .frame_start(c_fs)
  );

  int pcols[3] = '{5, 4, 6};
  int pring[3] = '{3, 4, 3};
  int pd[3]    = '{4, 2, 3};
  int pb[3]    = '{1, 0, 2};
  int pmir[3]  = '{1, 0, 1};
  int pal[3]   = '{0, 0, 1};

  // Model: stage number, position inside the DWELL+BLANK slot, wrap flag.
  int st[3];
  int t[3];
  int fs[3];

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s got %0h want %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      st[i] = pring[i] - 1;
      t[i]  = 0;
      fs[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      fs[i] = 0;
      if (enable) begin
        if (t[i] == pd[i] + pb[i] - 1) begin
          t[i] = 0;
          if (!reverse) begin
            if (st[i] == 0) begin
              st[i] = pring[i] - 1;
              fs[i] = 1;
            end else st[i]--;
          end else begin
            if (st[i] == pring[i] - 1) begin
              st[i] = 0;
              fs[i] = 1;
            end else st[i]++;
          end
        end else t[i]++;
      end
    end
  endtask

  function automatic int m_blank(int i);
    return (t[i] >= pd[i]) ? 1 : 0;
  endfunction

  function automatic int colm(int i);
    return (m_blank(i) != 0) ? 0 : (1 << st[i]);
  endfunction

  function automatic int exp_col(int i);
    int m;
    m = (1 << pring[i]) - 1;
    return (pal[i] != 0) ? (~colm(i) & m) : colm(i);
  endfunction

  function automatic int exp_phys(int i);
    int v;
    int cm;
    v  = 0;
    cm = colm(i);
    for (int p = 0; p < pcols[i]; p++) begin
      int q;
      int s;
      q = pcols[i] - 1 - p;
      s = (pmir[i] != 0) ? ((p < q) ? p : q) : p;
      if (((cm >> s) & 1) != 0) v = v | (1 << p);
    end
    if (pal[i] != 0) v = ~v & ((1 << pcols[i]) - 1);
    return v;
  endfunction

  task automatic check_all();
    int ac[3], ap[3], ai[3], ab[3], af[3];
    ac[0] = int'(a_col); ap[0] = int'(a_phys); ai[0] = int'(a_idx);
    ab[0] = int'(a_blank); af[0] = int'(a_fs);
    ac[1] = int'(b_col); ap[1] = int'(b_phys); ai[1] = int'(b_idx);
    ab[1] = int'(b_blank); af[1] = int'(b_fs);
    ac[2] = int'(c_col); ap[2] = int'(c_phys); ai[2] = int'(c_idx);
    ab[2] = int'(c_blank); af[2] = int'(c_fs);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("col[%0d] @%0t", i, $time), ac[i], exp_col(i));
      chk($sformatf("phys[%0d] @%0t", i, $time), ap[i], exp_phys(i));
      chk($sformatf("idx[%0d] @%0t", i, $time), ai[i], st[i]);
      chk($sformatf("blank[%0d] @%0t", i, $time), ab[i], m_blank(i));
      chk($sformatf("fs[%0d] @%0t", i, $time), af[i], fs[i]);
    end
  endtask

  task automatic drive(input logic p, input logic e, input logic r);
    @(negedge clock);
    pulse   = p;
    enable  = e;
    reverse = r;
    if (!p) model_reset();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clock);
    if (pulse) model_step();
  endtask

  logic [2:0] exp_a[16] = '{
    3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
    3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
    3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
    3'b100
  };
  logic [3:0] exp_b[8] = '{
    4'b1000, 4'b1000, 4'b0100, 4'b0100,
    4'b0010, 4'b0010, 4'b0001, 4'b0001
  };

  initial begin
    int seen;
    int prev;
    int k;
    logic rp, re, rr;
    model_reset();

    // Reset values, including the active-low instance.
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    chk("rst_a_col", int'(a_col), 3'b100);
    chk("rst_a_idx", int'(a_idx), 2);
    chk("rst_a_blank", int'(a_blank), 0);
    chk("rst_a_fs", int'(a_fs), 0);
    chk("rst_c_col", int'(c_col), 3'b011);
    tick();

    // Default scan sequence and the DWELL=2/BLANK=0 instance.
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk($sformatf("seq_a_col%0d", c), int'(a_col), int'(exp_a[c]));
      chk($sformatf("seq_a_fs%0d", c), int'(a_fs), (c == 15) ? 1 : 0);
      if (exp_a[c] == 3'b100)
        chk($sformatf("seq_a_phys%0d", c), int'(a_phys), 5'b00100);
      if (exp_a[c] == 3'b001)
        chk($sformatf("seq_a_phys%0d", c), int'(a_phys), 5'b10001);
      if (c < 8) begin
        chk($sformatf("seq_b_col%0d", c), int'(b_col), int'(exp_b[c]));
        chk($sformatf("seq_b_blank%0d", c), int'(b_blank), 0);
      end
      tick();
    end

    // Reverse flip while at stage 1.
    k = 0;
    while (!(st[0] == 1 && t[0] < pd[0]) && k < 40) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
      k++;
    end
    chk("nav_stage1", (st[0] == 1) ? 1 : 0, 1);
    seen = 0;
    prev = 1;
    k = 0;
    while (seen < 2 && k < 20) begin
      drive(1'b1, 1'b1, 1'b1);
      if (int'(a_idx) != prev) begin
        seen++;
        if (seen == 1) chk("rev_next_idx", int'(a_idx), 2);
        if (seen == 2) begin
          chk("rev_wrap_idx", int'(a_idx), 0);
          chk("rev_wrap_fs", int'(a_fs), 1);
        end
        prev = int'(a_idx);
      end
      tick();
      k++;
    end
    chk("rev_seen", seen, 2);

    // Freeze in the middle of blanking.
    k = 0;
    while (t[0] < pd[0] && k < 20) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
      k++;
    end
    for (int h = 0; h < 7; h++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk($sformatf("hold_blank%0d", h), int'(a_blank), 1);
      chk($sformatf("hold_col%0d", h), int'(a_col), 0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("hold_resume_blank", int'(a_blank), 1);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    chk("hold_done_blank", int'(a_blank), 0);
    tick();

    // Active-low blanking drives all ones.
    k = 0;
    while (t[2] < pd[2] && k < 20) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
      k++;
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("al_blank_col", int'(c_col), 3'b111);
    chk("al_blank_phys", int'(c_phys), 6'b111111);
    tick();

    // Asynchronous reset mid-dwell at stage 0.
    k = 0;
    while (!(st[0] == 0 && t[0] == 2) && k < 40) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
      k++;
    end
    chk("nav_stage0", (st[0] == 0) ? 1 : 0, 1);
    drive(1'b0, 1'b1, 1'b0);
    chk("async_a_col", int'(a_col), 3'b100);
    chk("async_a_idx", int'(a_idx), 2);
    chk("async_c_col", int'(c_col), 3'b011);
    tick();

    // Randomised run.
    rr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rp = ($urandom_range(0, 199) != 0);
      re = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rr = ~rr;
      drive(rp, re, rr);
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
